// File: rtl/dap_gpio_seq.sv
// GPIO command sequencer: turns set/clear/masked-write/sample commands
// into register-port cycles on a GPIO block and returns sampled inputs.
module dap_gpio_seq #(
   parameter int ADDRWIDTH = 12,
   parameter int BASE_ADDR = 0,
   parameter int GPIO_NUM  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_op,
   input  logic [GPIO_NUM-1:0]  cmd_mask,
   input  logic [GPIO_NUM-1:0]  cmd_data,
   input  logic [15:0]          cmd_hold,
   output logic                 rsp_valid,
   output logic [GPIO_NUM-1:0]  rsp_data,
   output logic                 busy,
   output logic                 gpio_write_en,
   output logic [ADDRWIDTH-1:0] gpio_addr,
   output logic [31:0]          gpio_wdata,
   output logic [3:0]           gpio_byte_strobe,
   input  logic [31:0]          gpio_rdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_HOLD,
      S_SAMPLE,
      S_DONE
   } state_t;

   localparam logic [ADDRWIDTH-1:0] A_DO = ADDRWIDTH'(BASE_ADDR + 8);
   localparam logic [ADDRWIDTH-1:0] A_DI = ADDRWIDTH'(BASE_ADDR + 12);
   localparam logic [ADDRWIDTH-1:0] A_BS = ADDRWIDTH'(BASE_ADDR + 16);
   localparam logic [ADDRWIDTH-1:0] A_BR = ADDRWIDTH'(BASE_ADDR + 20);

   state_t                 state_q;
   logic [1:0]             op_q;
   logic [GPIO_NUM-1:0]    mask_q;
   logic [GPIO_NUM-1:0]    data_q;
   logic [15:0]            hold_q;
   logic [15:0]            cnt_q;
   logic [GPIO_NUM-1:0]    shadow_q;
   logic [GPIO_NUM-1:0]    rsp_data_q;
   logic                   rsp_valid_q;
   logic                   busy_q;
   logic                   cmd_ready_q;
   logic                   we_q;
   logic [ADDRWIDTH-1:0]   addr_q;
   logic [31:0]            wdata_q;
   logic [3:0]             strb_q;

   logic [GPIO_NUM-1:0]    rd_d;
   logic [GPIO_NUM-1:0]    merge_d;
   logic                   unused_rdata;

   assign rd_d         = gpio_rdata[GPIO_NUM-1:0];
   assign unused_rdata = ^gpio_rdata[31:GPIO_NUM];
   // Merge uses the live DO read so the write data is ready on entry to WRITE
   assign merge_d      = (rd_d & ~mask_q) | (data_q & mask_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         mask_q      <= '0;
         data_q      <= '0;
         hold_q      <= '0;
         cnt_q       <= '0;
         shadow_q    <= '0;
         rsp_data_q  <= '0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         cmd_ready_q <= 1'b1;
         we_q        <= 1'b0;
         addr_q      <= A_DI;
         wdata_q     <= '0;
         strb_q      <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= A_DI;
         wdata_q     <= '0;
         strb_q      <= '0;
         unique case (state_q)
            S_IDLE: begin
               if (cmd_valid && cmd_ready_q) begin
                  op_q        <= cmd_op;
                  mask_q      <= cmd_mask;
                  data_q      <= cmd_data;
                  hold_q      <= cmd_hold;
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  unique case (cmd_op)
                     2'b10: begin
                        state_q <= S_READ;
                        addr_q  <= A_DO;
                     end
                     2'b11: begin
                        state_q <= S_SAMPLE;
                     end
                     default: begin
                        state_q <= S_WRITE;
                        we_q    <= 1'b1;
                        strb_q  <= 4'b1111;
                        addr_q  <= (cmd_op == 2'b00) ? A_BS : A_BR;
                        wdata_q <= 32'(cmd_mask);
                     end
                  endcase
               end
            end
            S_READ: begin
               shadow_q <= rd_d;
               state_q  <= S_WRITE;
               we_q     <= 1'b1;
               strb_q   <= 4'b1111;
               addr_q   <= A_DO;
               wdata_q  <= 32'(merge_d);
            end
            S_WRITE: begin
               if (hold_q != 16'd0) begin
                  state_q <= S_HOLD;
                  cnt_q   <= hold_q;
               end else begin
                  state_q <= S_SAMPLE;
               end
            end
            S_HOLD: begin
               if (cnt_q <= 16'd1) begin
                  state_q <= S_SAMPLE;
                  cnt_q   <= 16'd0;
               end else begin
                  cnt_q   <= cnt_q - 16'd1;
               end
            end
            S_SAMPLE: begin
               rsp_data_q  <= rd_d;
               rsp_valid_q <= 1'b1;
               state_q     <= S_DONE;
            end
            S_DONE: begin
               state_q     <= S_IDLE;
               busy_q      <= 1'b0;
               cmd_ready_q <= 1'b1;
            end
            default: begin
               state_q     <= S_IDLE;
               busy_q      <= 1'b0;
               cmd_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign cmd_ready        = cmd_ready_q;
   assign rsp_valid        = rsp_valid_q;
   assign rsp_data         = rsp_data_q;
   assign busy             = busy_q;
   assign gpio_write_en    = we_q;
   assign gpio_addr        = addr_q;
   assign gpio_wdata       = wdata_q;
   assign gpio_byte_strobe = strb_q;

endmodule
